// File: rtl/spart_driver_pkg.sv
// Shared definitions for the spart bus master: register addresses,
// baud-select codes, FSM states and the divisor formula.
package spart_driver_pkg;

   // spart processor-side register map
   localparam logic [1:0] ADDR_BUF  = 2'b00;
   localparam logic [1:0] ADDR_STAT = 2'b01;
   localparam logic [1:0] ADDR_DBL  = 2'b10;
   localparam logic [1:0] ADDR_DBH  = 2'b11;

   // br_cfg switch encodings
   localparam logic [1:0] BR_4800  = 2'b00;
   localparam logic [1:0] BR_9600  = 2'b01;
   localparam logic [1:0] BR_19200 = 2'b10;
   localparam logic [1:0] BR_38400 = 2'b11;

   typedef enum logic [2:0] {
      PROG_LO,
      PROG_HI,
      IDLE,
      READ,
      WAIT_TBR,
      WRITE
   } state_t;

   // Baud divisor: clk_freq / (oversample * baud) - 1, integer floor
   function automatic logic [15:0] calc_div(input int unsigned clk_freq,
                                            input int unsigned oversample,
                                            input int unsigned baud);
      int unsigned q;
      q = clk_freq / (oversample * baud) - 1;
      return q[15:0];
   endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control and status side of the spart processor interface.
// The 8-bit data bus stays a plain inout port on the driver.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, input rda, tbr);
   modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs (switches).
module spart_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Shift the raw input through two flops; both clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spart_driver.sv
// spart bus master: programs the baud divisor selected by br_cfg, then
// echoes every received byte back to the transmitter. Bus outputs are
// registered and decoded for the state being entered.
module spart_driver
   import spart_driver_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    br_cfg,
   spart_driver_if.master bus,
   inout  wire  [7:0]    databus,
   output logic [7:0]    last_rx,
   output logic          prog_done
);

   localparam logic [15:0] DIV_4800  = calc_div(CLK_FREQ, OVERSAMPLE, 4800);
   localparam logic [15:0] DIV_9600  = calc_div(CLK_FREQ, OVERSAMPLE, 9600);
   localparam logic [15:0] DIV_19200 = calc_div(CLK_FREQ, OVERSAMPLE, 19200);
   localparam logic [15:0] DIV_38400 = calc_div(CLK_FREQ, OVERSAMPLE, 38400);

   logic [1:0]  cfg_sync;
   logic [15:0] div_sel;

   state_t      state_q,     state_d;
   logic        iocs_q,      iocs_d;
   logic        iorw_q,      iorw_d;
   logic [1:0]  ioaddr_q,    ioaddr_d;
   logic [7:0]  dout_q,      dout_d;
   logic [15:0] div_q,       div_d;
   logic [1:0]  cfg_lat_q,   cfg_lat_d;
   logic [1:0]  cfg_q,       cfg_d;
   logic [7:0]  last_rx_q,   last_rx_d;
   logic        prog_done_q, prog_done_d;
   logic [1:0]  warm_q,      warm_d;

   spart_sync2 #(.WIDTH(2)) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (br_cfg),
      .q     (cfg_sync)
   );

   // Divisor constant for the synchronized baud selection
   always_comb begin
      case (cfg_sync)
         BR_4800:  div_sel = DIV_4800;
         BR_9600:  div_sel = DIV_9600;
         BR_19200: div_sel = DIV_19200;
         BR_38400: div_sel = DIV_38400;
         default:  div_sel = DIV_9600;
      endcase
   end

   // Next state and next registered bus outputs
   always_comb begin
      state_d     = state_q;
      iocs_d      = 1'b0;
      iorw_d      = 1'b1;
      ioaddr_d    = ADDR_BUF;
      dout_d      = dout_q;
      div_d       = div_q;
      cfg_lat_d   = cfg_lat_q;
      cfg_d       = cfg_q;
      last_rx_d   = last_rx_q;
      prog_done_d = prog_done_q;
      warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;

      case (state_q)
         PROG_LO: begin
            // iocs_q low here only straight out of reset: hold off until the
            // synchronizer carries real switch values, then issue the low byte
            if (iocs_q) begin
               state_d  = PROG_HI;
               iocs_d   = 1'b1;
               iorw_d   = 1'b0;
               ioaddr_d = ADDR_DBH;
               dout_d   = div_q[15:8];
            end else if (warm_q == 2'd2) begin
               iocs_d    = 1'b1;
               iorw_d    = 1'b0;
               ioaddr_d  = ADDR_DBL;
               dout_d    = div_sel[7:0];
               div_d     = div_sel;
               cfg_lat_d = cfg_sync;
            end
         end
         PROG_HI: begin
            // record the config whose divisor was written, so a switch change
            // between the two bytes still triggers another reprogram
            cfg_d       = cfg_lat_q;
            prog_done_d = 1'b1;
            state_d     = IDLE;
         end
         IDLE: begin
            if (cfg_sync != cfg_q) begin
               prog_done_d = 1'b0;
               state_d     = PROG_LO;
               iocs_d      = 1'b1;
               iorw_d      = 1'b0;
               ioaddr_d    = ADDR_DBL;
               dout_d      = div_sel[7:0];
               div_d       = div_sel;
               cfg_lat_d   = cfg_sync;
            end else if (bus.rda) begin
               state_d  = READ;
               iocs_d   = 1'b1;
               iorw_d   = 1'b1;
               ioaddr_d = ADDR_BUF;
            end
         end
         READ: begin
            last_rx_d = databus;
            state_d   = WAIT_TBR;
         end
         WAIT_TBR: begin
            if (bus.tbr) begin
               state_d  = WRITE;
               iocs_d   = 1'b1;
               iorw_d   = 1'b0;
               ioaddr_d = ADDR_BUF;
               dout_d   = last_rx_q;
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = PROG_LO;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PROG_LO;
         iocs_q      <= 1'b0;
         iorw_q      <= 1'b1;
         ioaddr_q    <= ADDR_BUF;
         dout_q      <= '0;
         div_q       <= '0;
         cfg_lat_q   <= '0;
         cfg_q       <= '0;
         last_rx_q   <= '0;
         prog_done_q <= 1'b0;
         warm_q      <= '0;
      end else begin
         state_q     <= state_d;
         iocs_q      <= iocs_d;
         iorw_q      <= iorw_d;
         ioaddr_q    <= ioaddr_d;
         dout_q      <= dout_d;
         div_q       <= div_d;
         cfg_lat_q   <= cfg_lat_d;
         cfg_q       <= cfg_d;
         last_rx_q   <= last_rx_d;
         prog_done_q <= prog_done_d;
         warm_q      <= warm_d;
      end
   end

   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign databus    = (iocs_q & ~iorw_q) ? dout_q : 8'hzz;
   assign last_rx    = last_rx_q;
   assign prog_done  = prog_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// Testbench for spart_driver: spart model with receive queue, expected
// bus-transaction scoreboard, and a monitor comparing every iocs cycle.
module tb_spart_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   wire  [7:0] databus;
   logic [7:0] last_rx;
   logic       prog_done;

   spart_driver_if bus();

   spart_driver #(.CLK_FREQ(100_000_000), .OVERSAMPLE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .br_cfg    (br_cfg),
      .bus       (bus.master),
      .databus   (databus),
      .last_rx   (last_rx),
      .prog_done (prog_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // expected transactions: {iorw, ioaddr, data}
   logic [10:0] exp_q[$];

   // spart receive side: bytes waiting to be read
   logic [7:0] rx_mem [256];
   int rx_pushed = 0;
   int rx_popped = 0;

   assign bus.rda = (rx_pushed != rx_popped);
   assign databus = (bus.iocs && bus.iorw) ? rx_mem[rx_popped[7:0]] : 8'hzz;

   function automatic logic [15:0] model_div(input logic [1:0] cfg);
      int unsigned baud;
      baud = 4800 * (1 << cfg);
      return 16'(100_000_000 / (16 * baud) - 1);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_prog(input logic [1:0] cfg);
      logic [15:0] d;
      d = model_div(cfg);
      exp_q.push_back({1'b0, 2'b10, d[7:0]});
      exp_q.push_back({1'b0, 2'b11, d[15:8]});
   endtask

   task automatic expect_echo(input logic [7:0] b);
      exp_q.push_back({1'b1, 2'b00, b});
      exp_q.push_back({1'b0, 2'b00, b});
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_mem[rx_pushed[7:0]] = b;
      rx_pushed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rx_pushed != rx_popped) && n < budget) begin
         tick();
         n++;
      end
      chk(name, 16'(exp_q.size()), 16'd0);
   endtask

   task automatic wait_read(input string name, input int budget);
      int n;
      n = 0;
      while (rx_popped != rx_pushed && n < budget) begin
         tick();
         n++;
      end
      chk(name, 16'(rx_pushed - rx_popped), 16'd0);
   endtask

   // Monitor: every cycle with iocs high is one transaction
   initial begin
      logic        prev_iocs;
      logic [1:0]  prev_addr;
      logic [10:0] act;
      logic [10:0] ex;
      prev_iocs = 1'b0;
      prev_addr = 2'b00;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            prev_iocs = 1'b0;
         end else if (bus.iocs) begin
            act = {bus.iorw, bus.ioaddr, bus.iorw ? rx_mem[rx_popped[7:0]] : databus};
            if (prev_iocs)
               chk("back_to_back", {12'd0, prev_addr, bus.ioaddr}, 16'h000B);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_mis++;
               $display("FAIL unexpected_txn: got %h expected none", act);
            end else begin
               ex = exp_q.pop_front();
               chk("bus_txn", 16'(act), 16'(ex));
            end
            prev_iocs = 1'b1;
            prev_addr = bus.ioaddr;
            if (bus.iorw) begin
               @(posedge clk);
               #1;
               chk("last_rx", 16'(last_rx), 16'(act[7:0]));
               rx_popped++;
            end
         end else begin
            prev_iocs = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] b;
      logic [1:0] c;
      int         gap;
      int         n;

      rst     = 1'b0;
      br_cfg  = 2'b01;
      bus.tbr = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_iocs", 16'(bus.iocs), 16'd0);
      chk("rst_iorw", 16'(bus.iorw), 16'd1);
      chk("rst_ioaddr", 16'(bus.ioaddr), 16'd0);
      chk("rst_last_rx", 16'(last_rx), 16'd0);
      chk("rst_prog_done", 16'(prog_done), 16'd0);

      // initial programming at 9600
      expect_prog(2'b01);
      tick();
      rst = 1'b1;
      wait_drain("t1_prog", 40);
      tick();
      chk("t1_prog_done", 16'(prog_done), 16'd1);

      // simple echo
      expect_echo(8'h41);
      send_byte(8'h41);
      wait_drain("t2_echo", 40);
      tick();
      chk("t2_last_rx", 16'(last_rx), 16'h0041);

      // transmitter busy for 20 cycles after the read
      bus.tbr = 1'b0;
      b = 8'($urandom);
      expect_echo(b);
      send_byte(b);
      wait_read("t3_read", 40);
      repeat (20) begin
         @(negedge clk);
         chk("t3_hold_iocs", 16'(bus.iocs), 16'd0);
      end
      tick();
      bus.tbr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t3_write_cycle", {12'd0, bus.iocs, bus.iorw, bus.ioaddr}, 16'h0008);
      wait_drain("t3_drain", 40);
      tick();

      // br_cfg change while idle, byte arrives while reprogramming
      expect_prog(2'b11);
      br_cfg = 2'b11;
      n = 0;
      while (prog_done !== 1'b0 && n < 4) begin
         @(negedge clk);
         n++;
      end
      chk("t4_prog_drop", 16'(prog_done), 16'd0);
      b = 8'($urandom);
      expect_echo(b);
      send_byte(b);
      wait_drain("t4_drain", 60);
      tick();
      chk("t4_prog_done", 16'(prog_done), 16'd1);

      // br_cfg change while waiting for tbr: echo completes first
      bus.tbr = 1'b0;
      b = 8'($urandom);
      expect_echo(b);
      send_byte(b);
      wait_read("t5_read", 40);
      c = br_cfg + 2'(1 + $urandom_range(0, 2));
      expect_prog(c);
      br_cfg = c;
      repeat (6) tick();
      bus.tbr = 1'b1;
      wait_drain("t5_drain", 60);
      tick();
      chk("t5_prog_done", 16'(prog_done), 16'd1);

      // randomized mix of echoes, bursts and reconfigurations
      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               gap = $urandom_range(0, 6);
               b = 8'($urandom);
               expect_echo(b);
               if (gap == 0) begin
                  send_byte(b);
               end else begin
                  bus.tbr = 1'b0;
                  send_byte(b);
                  wait_read("rnd_read", 40);
                  repeat (gap) tick();
                  bus.tbr = 1'b1;
               end
               wait_drain("rnd_echo", 60);
            end
            1: begin
               c = br_cfg + 2'(1 + $urandom_range(0, 2));
               expect_prog(c);
               br_cfg = c;
               wait_drain("rnd_prog", 60);
               tick();
               chk("rnd_prog_done", 16'(prog_done), 16'd1);
            end
            default: begin
               for (int k = 0; k < 4; k++) begin
                  b = 8'($urandom);
                  expect_echo(b);
                  send_byte(b);
               end
               wait_drain("rnd_burst", 120);
            end
         endcase
         tick();
      end

      // reset asserted while the echo write is on the bus
      bus.tbr = 1'b0;
      b = 8'($urandom);
      exp_q.push_back({1'b1, 2'b00, b});
      send_byte(b);
      wait_read("t6_read", 40);
      repeat (3) tick();
      bus.tbr = 1'b1;
      tick();
      chk("t6_write_on_bus", {12'd0, bus.iocs, bus.iorw, bus.ioaddr}, 16'h0008);
      rst = 1'b0;
      #1;
      chk("t6_async_iocs", 16'(bus.iocs), 16'd0);
      chk("t6_async_iorw", 16'(bus.iorw), 16'd1);
      repeat (2) tick();
      chk("t6_last_rx", 16'(last_rx), 16'd0);
      chk("t6_prog_done", 16'(prog_done), 16'd0);
      chk("t6_queue", 16'(exp_q.size()), 16'd0);
      expect_prog(br_cfg);
      rst = 1'b1;
      wait_drain("t6_reprog", 40);
      tick();
      chk("t6_prog_done_after", 16'(prog_done), 16'd1);

      repeat (5) tick();
      chk("final_queue", 16'(exp_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
